// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Used by dmem_responder (DMEM_ERR_CHECK_EN selects error checking).
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic size_e norm_size(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(
    input size_e      sz,
    input logic [1:0] off
  );
    unique case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(
    input size_e       sz,
    input logic [31:0] d
  );
    unique case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend(
    input size_e       sz,
    input logic        uns,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [31:0] s;
    s = w >> {off, 3'b000};
    unique case (sz)
      SZ_BYTE: return {{24{~uns & s[7]}}, s[7:0]};
      SZ_HALF: return {{16{~uns & s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_1rw.sv
// Single-port 32-bit word array with byte enables and registered read.
// Contents are intentionally not reset.
module dmem_sram_1rw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait, response.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, uns_q, err_q;
  size_e                 size_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;

  size_e       acc_size;
  logic [1:0]  acc_off;
  logic        acc_err;
  logic        accept;
  logic        sram_en;
  logic [31:0] sram_rdata;

  assign acc_size = norm_size(req_size_i);
  assign accept   = (state_q == ST_IDLE) && req_valid_i;

`ifdef DMEM_ERR_CHECK_EN
  assign acc_off = req_addr_i[1:0];
  assign acc_err =
    ((acc_size == SZ_HALF) && req_addr_i[0]) ||
    ((acc_size == SZ_WORD) && (req_addr_i[1:0] != 2'b00)) ||
    ((req_addr_i >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
  logic unused_addr;
  assign unused_addr = ^req_addr_i;
  // Force natural alignment instead of reporting it.
  always_comb begin
    acc_off = req_addr_i[1:0];
    unique case (acc_size)
      SZ_BYTE: acc_off = req_addr_i[1:0];
      SZ_HALF: acc_off = {req_addr_i[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
  end
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_WORD;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write_i;
        uns_q   <= req_unsigned_i;
        err_q   <= acc_err;
        size_q  <= acc_size;
        idx_q   <= req_addr_i[DEPTH_LOG2+1:2];
        off_q   <= acc_off;
        wdata_q <= req_wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sram_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          sram_en = ~err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dmem_sram_1rw #(
    .AW(DEPTH_LOG2)
  ) u_sram (
    .clk    (clk),
    .en_i   (sram_en),
    .we_i   (write_q),
    .be_i   (lane_mask(size_q, off_q)),
    .addr_i (idx_q),
    .wdata_i(lane_data(size_q, wdata_q)),
    .rdata_o(sram_rdata)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o =
    (rsp_valid_o && !write_q && !err_q) ?
    extend(size_q, uns_q, off_q, sram_rdata) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Reference model keeps the array as plain words and does byte arithmetic.
module tb_dmem_responder;

  localparam int DL = 4;
  localparam int WS = 2;
  localparam int NW = 1 << DL;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [NW];

  dmem_responder #(
    .DEPTH_LOG2 (DL),
    .WAIT_STATES(WS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_size_i    (req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [1:0]  sz,
    input  bit          u,
    output logic [31:0] rd,
    output logic        er
  );
    int nb, idx, off;
    longint aa;
    logic [31:0] v, m;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    aa = longint'(a);
`ifdef DMEM_ERR_CHECK_EN
    er = ((aa % nb) != 0) || (aa >= 4 * NW);
`else
    er = 1'b0;
    aa = aa - (aa % nb);
`endif
    idx = int'((aa / 4) % NW);
    off = int'(aa % 4);
    rd  = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++)
          ref_mem[idx][8*(off+i) +: 8] = d[8*i +: 8];
      end else begin
        m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
        v = (ref_mem[idx] >> (8 * off)) & m;
        if (!u && nb < 4 && v[8*nb-1]) v = v | ~m;
        rd = v;
      end
    end
  endtask

  task automatic do_req(
    input bit          w,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [1:0]  sz,
    input bit          u,
    input int          hold
  );
    logic [31:0] erd;
    logic        eer;
    int          n;
    model(w, a, d, sz, u, erd, eer);
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_write_i    = w;
    req_addr_i     = a;
    req_wdata_i    = d;
    req_size_i     = sz;
    req_unsigned_i = u;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    n = 0;
    while (!rsp_valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, WS + 1);
    chk("rdata", rsp_rdata_o, erd);
    chk("err", {31'd0, rsp_err_o}, {31'd0, eer});
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_rdata", rsp_rdata_o, erd);
      chk("hold_err", {31'd0, rsp_err_o}, {31'd0, eer});
      chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    chk("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_err"}, {31'd0, rsp_err_o}, 32'd0);
  endtask

  initial begin
    int acc_cyc[$];
    int cyc;
    logic [31:0] erd, a, d;
    logic eer;
    rst            = 1'b0;
    req_valid_i    = 1'b0;
    req_write_i    = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    rsp_ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NW; i++)
      do_req(1'b1, 32'(4 * i), $urandom, 2'd2, 1'b0, 0);

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);

    do_req(1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0);
    do_req(1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 0);
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0);
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
    chk("sb_lane_word", ref_mem[4], 32'h8000_0000);

    do_req(1'b1, 32'h18, 32'h1234_5678, 2'd2, 1'b0, 5);
    do_req(1'b0, 32'h18, 32'h0, 2'd2, 1'b0, 0);

    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h20;
    req_wdata_i = 32'hCAFE_F00D;
    req_size_i  = 2'd2;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);

    do_req(1'b0, 32'h02, 32'h0, 2'd2, 1'b0, 0);
    do_req(1'b0, 32'h3F, 32'h0, 2'd1, 1'b0, 0);
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4 * NW - 1))
                                      : $urandom;
      do_req(1'($urandom_range(0, 1)), a, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    model(1'b0, 32'h04, 32'h0, 2'd2, 1'b0, erd, eer);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h04;
    req_size_i  = 2'd2;
    rsp_ready_i = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      if (rsp_valid_o) chk("b2b_rdata", rsp_rdata_o, erd);
      if (req_ready_o) begin
        if (acc_cyc.size() == 5) break;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("b2b_count", acc_cyc.size(), 5);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], WS + 3);

    d = 32'h0;
    @(posedge clk); #1;
    chk("final_idle", {31'd0, req_ready_o}, {31'd0, ~d[0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
